// File: rtl/axi_master_burst_engine.sv
// AXI4 burst initiator: one outstanding AW+W+B or AR+R transaction per command, merged completion.
// Latency: accept -> a*valid next cycle; bvalid or final rlast -> done_valid next cycle.
// Backpressure: W/R streams pass through combinationally; cmd_ready only in IDLE.
module axi_master_burst_engine #(
  parameter logic [1:0] BURST = 2'b01,
  parameter logic [3:0] CACHE = 4'b0011,
  parameter logic [2:0] PROT  = 3'b000,
  parameter logic [3:0] QOS   = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [3:0]  cmd_id,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [31:0] rd_data,
  output logic [1:0]  rd_resp,
  output logic        rd_last,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        done_valid,
  output logic [1:0]  done_resp,
  output logic        done_err,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic [3:0]  awqos,
  output logic [3:0]  awregion,
  output logic        awuser,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wuser,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        buser,
  input  logic        bvalid,
  output logic        bready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic [3:0]  arqos,
  output logic [3:0]  arregion,
  output logic        aruser,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        ruser,
  input  logic        rvalid,
  output logic        rready
);
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q;
  logic [7:0]  len_q, beat_q;
  logic [3:0]  id_q;
  logic [1:0]  resp_q;
  logic        err_q;
  logic        cmd_hs, reject, w_hs, r_hs, last_beat, unused_user;
  logic [13:0] end_off;

  assign cmd_hs      = cmd_valid && cmd_ready;
  // end offset of the burst within its 4KB page; anything past 4096 crosses
  assign end_off     = {2'b00, cmd_addr[11:0]} + {4'b0000, cmd_len, 2'b00} + 14'd4;
  assign reject      = (cmd_addr[1:0] != 2'b00) || (end_off > 14'd4096);
  assign w_hs        = wvalid && wready;
  assign r_hs        = rvalid && rready;
  assign last_beat   = (beat_q == len_q);
  assign unused_user = buser ^ ruser;

  assign awid = id_q;     assign awaddr = addr_q;  assign awlen = len_q;   assign awsize = 3'd2;
  assign awburst = BURST; assign awlock = 1'b0;    assign awcache = CACHE; assign awprot = PROT;
  assign awqos = QOS;     assign awregion = 4'h0;  assign awuser = 1'b0;
  assign arid = id_q;     assign araddr = addr_q;  assign arlen = len_q;   assign arsize = 3'd2;
  assign arburst = BURST; assign arlock = 1'b0;    assign arcache = CACHE; assign arprot = PROT;
  assign arqos = QOS;     assign arregion = 4'h0;  assign aruser = 1'b0;
  assign wdata = wr_data; assign wstrb = wr_strb;  assign wlast = last_beat; assign wuser = 1'b0;
  assign rd_data = rdata; assign rd_resp = rresp;  assign rd_last = rlast;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_hs) state_nxt = reject ? DONE : (cmd_write ? WR_ADDR : RD_ADDR);
      WR_ADDR: if (awready) state_nxt = WR_DATA;
      WR_DATA: if (w_hs && last_beat) state_nxt = WR_RESP;
      WR_RESP: if (bvalid) state_nxt = DONE;
      RD_ADDR: if (arready) state_nxt = RD_DATA;
      RD_DATA: if (r_hs && rlast) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    wr_ready   = 1'b0;
    bready     = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    rd_valid   = 1'b0;
    done_valid = 1'b0;
    done_resp  = 2'b00;
    done_err   = 1'b0;
    case (state)
      IDLE:    cmd_ready = !reset;
      WR_ADDR: awvalid = 1'b1;
      WR_DATA: begin wvalid = wr_valid; wr_ready = wready; end
      WR_RESP: bready = 1'b1;
      RD_ADDR: arvalid = 1'b1;
      RD_DATA: begin rd_valid = rvalid; rready = rd_ready; end
      DONE:    begin done_valid = 1'b1; done_resp = resp_q; done_err = err_q; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      len_q  <= '0;
      id_q   <= '0;
      beat_q <= '0;
      resp_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_hs) begin
          addr_q <= cmd_addr;
          len_q  <= cmd_len;
          id_q   <= cmd_id;
          beat_q <= '0;
          resp_q <= reject ? 2'b10 : 2'b00;
          err_q  <= reject;
        end
        WR_DATA: if (w_hs) beat_q <= beat_q + 8'd1;
        WR_RESP: if (bvalid) begin
          resp_q <= bresp;
          err_q  <= err_q | (bid != id_q);
        end
        RD_DATA: if (r_hs) begin
          resp_q <= (rresp > resp_q) ? rresp : resp_q;
          // rlast must coincide with the final counted beat; beats past it are drained
          err_q  <= err_q | (rid != id_q) | (rlast != last_beat);
          if (!last_beat) beat_q <= beat_q + 8'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_master_burst_engine.sv
// Bench for axi_master_burst_engine: AXI slave/stream models plus a per-command reference model.
module tb_axi_master_burst_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr; logic [7:0] cmd_len; logic [3:0] cmd_id;
  logic [31:0] wr_data; logic [3:0] wr_strb; logic wr_valid, wr_ready;
  logic [31:0] rd_data; logic [1:0] rd_resp; logic rd_last, rd_valid, rd_ready;
  logic done_valid, done_err; logic [1:0] done_resp;
  logic [3:0] awid, awcache, awqos, awregion; logic [31:0] awaddr; logic [7:0] awlen; logic [2:0] awsize, awprot;
  logic [1:0] awburst; logic awlock, awuser, awvalid, awready;
  logic [31:0] wdata; logic [3:0] wstrb; logic wlast, wuser, wvalid, wready;
  logic [3:0] bid; logic [1:0] bresp; logic buser, bvalid, bready;
  logic [3:0] arid, arcache, arqos, arregion; logic [31:0] araddr; logic [7:0] arlen; logic [2:0] arsize, arprot;
  logic [1:0] arburst; logic arlock, aruser, arvalid, arready;
  logic [3:0] rid; logic [31:0] rdata; logic [1:0] rresp; logic rlast, ruser, rvalid, rready;

  axi_master_burst_engine dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data), .rd_resp(rd_resp), .rd_last(rd_last),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .done_valid(done_valid), .done_resp(done_resp), .done_err(done_err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awqos(awqos), .awregion(awregion), .awuser(awuser),
    .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wuser(wuser),
    .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp), .buser(buser), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arqos(arqos), .arregion(arregion), .aruser(aruser),
    .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .ruser(ruser), .rvalid(rvalid), .rready(rready)
  );

  typedef struct { logic [31:0] d; logic [3:0] s; } wbeat_t;
  typedef struct { logic [31:0] d; logic [1:0] r; logic l; logic [3:0] id; } rbeat_t;

  int total = 0, bad = 0, cyc = 0;
  wbeat_t wq[$]; rbeat_t rq[$]; rbeat_t robs[$];
  logic [31:0] wobs_d[$]; logic [3:0] wobs_s[$]; logic wobs_l[$];
  bit rand_rdy, aw_seen, ar_seen, b_pend, aw_prev, wuser_seen;
  int aw_delay, aw_wait, aw_stalls, aw_vld_cnt, ar_vld_cnt, aw_unstable, w_early, w_cnt, done_cnt, hs_cyc;
  logic [1:0] cfg_bresp; logic [3:0] cfg_bid, prev_id;
  logic [31:0] prev_addr, cap_addr; logic [7:0] prev_len; logic [33:0] cap_ctl;

  always @(posedge clk) cyc <= cyc + 1;

  // slave side and stream endpoints: drive at the falling edge, observe the coming handshake 1ns later
  always @(negedge clk) begin
    awready = awvalid && (aw_wait >= aw_delay);
    arready = arvalid && (!rand_rdy || $urandom_range(0, 2) != 0);
    wready  = !rand_rdy || $urandom_range(0, 3) != 0;
    if (wq.size() > 0 && (!rand_rdy || $urandom_range(0, 3) != 0)) begin
      wr_valid = 1'b1; wr_data = wq[0].d; wr_strb = wq[0].s;
    end else begin
      wr_valid = 1'b0; wr_data = '0; wr_strb = '0;
    end
    bvalid = b_pend; bresp = cfg_bresp; bid = cfg_bid; buser = 1'b0; ruser = 1'b0;
    if (ar_seen && rq.size() > 0 && (!rand_rdy || $urandom_range(0, 3) != 0)) begin
      rvalid = 1'b1; rdata = rq[0].d; rresp = rq[0].r; rlast = rq[0].l; rid = rq[0].id;
    end else begin
      rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rid = '0;
    end
    rd_ready = !rand_rdy || $urandom_range(0, 3) != 0;
    #1;
    if (awvalid) begin
      aw_vld_cnt++;
      if (aw_prev && (awaddr != prev_addr || awlen != prev_len || awid != prev_id)) aw_unstable++;
      prev_addr = awaddr; prev_len = awlen; prev_id = awid;
    end
    aw_prev = awvalid && !awready;
    if (wvalid && !aw_seen) w_early++;
    if (awvalid && awready) begin
      aw_seen = 1; aw_stalls = aw_wait; aw_wait = 0; cap_addr = awaddr;
      cap_ctl = {awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser};
    end else if (awvalid) aw_wait++;
    if (arvalid) ar_vld_cnt++;
    if (arvalid && arready) begin
      ar_seen = 1; cap_addr = araddr;
      cap_ctl = {arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser};
    end
    if (wr_valid && wr_ready) void'(wq.pop_front());
    if (wvalid && wready) begin
      wobs_d.push_back(wdata); wobs_s.push_back(wstrb); wobs_l.push_back(wlast);
      wuser_seen |= wuser; w_cnt++;
      if (wlast) b_pend = 1;
    end
    if (bvalid && bready) begin b_pend = 0; hs_cyc = cyc; end
    if (rvalid && rready) begin void'(rq.pop_front()); if (rlast) hs_cyc = cyc; end
    if (rd_valid && rd_ready) robs.push_back('{rd_data, rd_resp, rd_last, 4'h0});
    if (done_valid) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    aw_seen = 0; ar_seen = 0; b_pend = 0; aw_prev = 0; wuser_seen = 0;
    aw_wait = 0; aw_stalls = 0; aw_vld_cnt = 0; ar_vld_cnt = 0; aw_unstable = 0; w_early = 0;
    w_cnt = 0; done_cnt = 0; hs_cyc = -100;
    wq.delete(); rq.delete(); robs.delete(); wobs_d.delete(); wobs_s.delete(); wobs_l.delete();
  endtask

  // One command end to end; expectations come from the address/len rules and the planned slave replies.
  task automatic run_cmd(input bit wr, input logic [31:0] a, input logic [7:0] len, input logic [3:0] id,
                         input logic [1:0] b_resp, input logic [3:0] b_id,
                         input int last_pos, input int bad_idx, input int force_idx, input bit rnd_resp);
    bit rej, exp_err; logic [1:0] exp_resp; int n, off, beats;
    wbeat_t exp_w[$]; rbeat_t exp_r[$];
    off = a % 4096; beats = len + 1;
    rej = (a % 4 != 0) || (off + 4 * beats > 4096);
    clear_mon();
    cfg_bresp = b_resp; cfg_bid = b_id;
    exp_resp = 2'b10; exp_err = 1;
    if (!rej && wr) begin
      for (int i = 0; i < beats; i++) begin
        wbeat_t b;
        b.d = $urandom; b.s = 4'($urandom);
        exp_w.push_back(b); wq.push_back(b);
      end
      exp_resp = b_resp; exp_err = (b_id != id);
    end else if (!rej) begin
      exp_resp = 2'b00; exp_err = (last_pos != len);
      for (int i = 0; i <= last_pos; i++) begin
        rbeat_t b;
        b.d = $urandom;
        b.r = rnd_resp ? 2'($urandom) : ((i == force_idx) ? 2'b10 : 2'b00);
        b.l = (i == last_pos);
        b.id = (i == bad_idx) ? 4'(id + 1) : id;
        if (b.id != id) exp_err = 1;
        if (b.r > exp_resp) exp_resp = b.r;
        exp_r.push_back(b); rq.push_back(b);
      end
    end
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = len; cmd_id = id;
    @(negedge clk);
    cmd_valid = 0; cmd_addr = $urandom; cmd_len = 8'($urandom); cmd_id = 4'($urandom);
    if (rej) chk("reject_no_addr_valid", {awvalid, arvalid}, 0);
    else chk("addr_valid_latency", wr ? awvalid : arvalid, 1);
    n = 0;
    while (done_valid !== 1'b1 && n < 1500) begin @(negedge clk); n++; end
    chk("done_seen", done_valid, 1);
    if (rej) chk("reject_done_immediate", n, 0);
    else chk("done_latency", cyc, hs_cyc + 1);
    chk("done_resp", done_resp, exp_resp);
    chk("done_err", done_err, exp_err);
    @(negedge clk);
    chk("done_one_cycle", done_valid, 0);
    if (n >= 1500) begin reset = 1; @(negedge clk); reset = 0; end
    if (rej) chk("reject_no_bus", aw_vld_cnt + ar_vld_cnt + wobs_d.size() + robs.size(), 0);
    else if (wr) begin
      chk("aw_addr", cap_addr, a);
      chk("aw_fields", cap_ctl, {id, len, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0, 4'h0, 1'b0});
      chk("aw_stable", aw_unstable, 0);
      chk("aw_stall_cycles", aw_stalls, aw_delay);
      chk("w_after_aw", w_early, 0);
      chk("wuser_zero", wuser_seen, 0);
      chk("w_beats", wobs_d.size(), beats);
      for (int i = 0; i < beats && i < wobs_d.size(); i++) begin
        chk($sformatf("wdata[%0d]", i), wobs_d[i], exp_w[i].d);
        chk($sformatf("wstrb[%0d]", i), wobs_s[i], exp_w[i].s);
        chk($sformatf("wlast[%0d]", i), wobs_l[i], i == int'(len));
      end
    end else begin
      chk("ar_addr", cap_addr, a);
      chk("ar_fields", cap_ctl, {id, len, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0, 4'h0, 1'b0});
      chk("aw_idle_on_read", aw_vld_cnt, 0);
      chk("rd_beats", robs.size(), exp_r.size());
      for (int i = 0; i < exp_r.size() && i < robs.size(); i++) begin
        chk($sformatf("rd_data[%0d]", i), robs[i].d, exp_r[i].d);
        chk($sformatf("rd_resp[%0d]", i), robs[i].r, exp_r[i].r);
        chk($sformatf("rd_last[%0d]", i), robs[i].l, exp_r[i].l);
      end
    end
  endtask

  initial begin
    int n;
    reset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_id = 0;
    rand_rdy = 0; aw_delay = 0; cfg_bresp = 0; cfg_bid = 0;
    clear_mon();
    repeat (3) @(negedge clk);
    chk("reset_valids", {awvalid, wvalid, arvalid, bready, rready, rd_valid, wr_ready}, 0);
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_done", {done_valid, done_resp, done_err}, 0);
    reset = 0;

    run_cmd(1, 32'h0000_1000, 8'd3, 4'd5, 2'b00, 4'd5, 0, -1, -1, 0);
    run_cmd(0, 32'h0000_2000, 8'd7, 4'd2, 2'b00, 4'd2, 7, -1, 5, 0);
    run_cmd(1, 32'h0000_0FF8, 8'd3, 4'd1, 2'b00, 4'd1, 0, -1, -1, 0);
    aw_delay = 10;
    run_cmd(1, 32'h0000_3000, 8'd2, 4'd4, 2'b01, 4'd4, 0, -1, -1, 0);
    aw_delay = 0;
    run_cmd(0, 32'h0000_2100, 8'd3, 4'd2, 2'b00, 4'd2, 1, 1, -1, 0);
    run_cmd(1, 32'h0000_0FFC, 8'd0, 4'd3, 2'b00, 4'd3, 0, -1, -1, 0);
    run_cmd(0, 32'h0000_0FFC, 8'd1, 4'd3, 2'b00, 4'd3, 1, -1, -1, 0);
    run_cmd(1, 32'h0000_5002, 8'd0, 4'd3, 2'b00, 4'd3, 0, -1, -1, 0);
    run_cmd(0, 32'h0000_6000, 8'd3, 4'd9, 2'b00, 4'd9, 5, -1, 4, 0);
    run_cmd(1, 32'h0000_7000, 8'd1, 4'd6, 2'b11, 4'd7, 0, -1, -1, 0);
    run_cmd(1, 32'h0000_3C00, 8'd255, 4'd8, 2'b00, 4'd8, 0, -1, -1, 0);
    run_cmd(0, 32'h0001_3C00, 8'd255, 4'd8, 2'b00, 4'd8, 255, -1, 200, 0);

    // reset in the middle of a 16-beat write
    clear_mon();
    for (int i = 0; i < 16; i++) wq.push_back('{$urandom, 4'hF});
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h0000_4000; cmd_len = 8'd15; cmd_id = 4'd1;
    @(negedge clk);
    cmd_valid = 0;
    n = 0;
    while (w_cnt < 1 && n < 50) begin @(negedge clk); n++; end
    chk("mid_burst_wvalid", wvalid, 1);
    reset = 1;
    @(negedge clk);
    chk("rst_mid_valids", {awvalid, wvalid, arvalid, bready, rready, rd_valid, wr_ready}, 0);
    chk("rst_mid_done", done_valid, 0);
    reset = 0;
    @(negedge clk);
    chk("rst_mid_idle", cmd_ready, 1);
    repeat (5) @(negedge clk);
    chk("rst_mid_no_done", done_cnt, 0);
    clear_mon();

    rand_rdy = 1;
    for (int k = 0; k < 20; k++) begin
      bit wr; logic [31:0] a; logic [7:0] len; logic [3:0] id, bidv; logic [1:0] br; int lp, bi;
      wr = 1'($urandom_range(0, 1));
      id = 4'($urandom);
      len = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 15));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: a[1:0] = 2'b00;
        1: a[11:0] = 12'(4096 - 4 * $urandom_range(1, 20));
        2: ;
        default: a[11:0] = 12'h000;
      endcase
      aw_delay = $urandom_range(0, 3);
      br = 2'($urandom);
      bidv = ($urandom_range(0, 3) == 0) ? 4'(id + 1) : id;
      lp = len;
      case ($urandom_range(0, 5))
        0: lp = len + 2;
        1: if (len > 0) lp = len - 1;
        default: ;
      endcase
      bi = ($urandom_range(0, 4) == 0) ? $urandom_range(0, lp) : -1;
      run_cmd(wr, a, len, id, br, bidv, lp, bi, -1, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
